// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM and its clear sequencer.
// The read-during-write bypass is selected elsewhere by the RAM_RDW_BYPASS_EN macro.
package ram_pkg;

  localparam int unsigned RAM_BYTE = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ram_state_t;

  // One byte lane of a write merge: the enabled lane takes the new byte.
  function automatic logic [RAM_BYTE-1:0] be_merge(
    input logic [RAM_BYTE-1:0] old_b,
    input logic [RAM_BYTE-1:0] new_b,
    input logic                be
  );
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: sweeps every address with zero data after reset or a clear
// request, then holds in RUN with ready asserted.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int unsigned AWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  output logic              ready_o,
  output logic              clr_we_o,
  output logic [AWIDTH-1:0] clr_addr_o
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

  ram_state_t        state_q;
  logic              ready_q;
  logic [AWIDTH-1:0] clr_addr_q;

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      ready_q    <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      unique case (state_q)
        INIT: begin
          if (clear_i) begin
            clr_addr_q <= '0;
          end else if (clr_addr_q == LAST_ADDR) begin
            state_q    <= RUN;
            ready_q    <= 1'b1;
            clr_addr_q <= '0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        RUN: begin
          if (clear_i) begin
            state_q    <= INIT;
            ready_q    <= 1'b0;
            clr_addr_q <= '0;
          end
        end
        default: begin
          state_q <= INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign clr_we_o   = (state_q == INIT);
  assign clr_addr_o = clr_addr_q;

endmodule

// File: rtl/ram_sync_dp_be.sv
// Simple dual-port synchronous RAM with per-byte write enables, read valid strobe,
// optional output register (OUT_REG) and hardware zeroing. Macro: RAM_RDW_BYPASS_EN.
module ram_sync_dp_be
  import ram_pkg::*;
#(
  parameter  int unsigned AWIDTH  = 3,
  parameter  int unsigned DWIDTH  = 32,
  parameter  int unsigned OUT_REG = 0,
  localparam int unsigned DEPTH   = 1 << AWIDTH,
  localparam int unsigned BE_W    = DWIDTH / 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  output logic              ready,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid
);

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              clr_we;
  logic [AWIDTH-1:0] clr_addr;
  logic              wr_fire;
  logic              rd_fire;
  logic [DWIDTH-1:0] merged_w;
  logic [DWIDTH-1:0] rd_word_d;

  ram_clr_seq #(
    .AWIDTH(AWIDTH)
  ) u_clr_seq (
    .clk       (clock),
    .rst_n     (reset_n),
    .clear_i   (clear),
    .ready_o   (ready),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

  // A clear in the same cycle as a write wins; the write is dropped.
  assign wr_fire = ready & wr_en & ~clear;
  assign rd_fire = ready & rd_en;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    merged_w = mem[wr_addr];
    for (int i = 0; i < BE_W; i++) begin
      merged_w[i*RAM_BYTE +: RAM_BYTE] = be_merge(mem[wr_addr][i*RAM_BYTE +: RAM_BYTE],
                                                  wr_data[i*RAM_BYTE +: RAM_BYTE], wr_be[i]);
    end
  end

  // NOTE: the array has no reset; the clear sweep zeroes it, which keeps it mappable to RAM.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr] <= merged_w;
    end
  end

`ifdef RAM_RDW_BYPASS_EN
  assign rd_word_d = (wr_fire && (wr_addr == rd_addr)) ? merged_w : mem[rd_addr];
`else
  assign rd_word_d = mem[rd_addr];
`endif

  logic              s1_valid_q;
  logic [DWIDTH-1:0] s1_data_q;
  logic              pipe_valid;
  logic [DWIDTH-1:0] pipe_data;
  logic              rd_valid_q;
  logic [DWIDTH-1:0] rd_data_q;

  // The array is sampled on the request edge so the unbypassed build sees the pre-write word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_fire;
      if (rd_fire) s1_data_q <= rd_word_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              s2_valid_q;
    logic [DWIDTH-1:0] s2_data_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign pipe_valid = s2_valid_q;
    assign pipe_data  = s2_data_q;
  end else begin : g_no_out_reg
    assign pipe_valid = s1_valid_q;
    assign pipe_data  = s1_data_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= pipe_valid;
      if (pipe_valid) rd_data_q <= pipe_data;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ram_sync_dp_be.sv
// Self-checking bench for ram_sync_dp_be against a behavioural array/queue model.
// Honours RAM_RDW_BYPASS_EN when computing same-address read-during-write results.
module tb_ram_sync_dp_be;

  localparam int AW      = 3;
  localparam int DW      = 32;
  localparam int OUT_REG = 0;
  localparam int LAT     = 1 + OUT_REG;
  localparam int DEPTH   = 1 << AW;
  localparam int BEW     = DW / 8;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b1;
  logic          clear   = 1'b0;
  logic          ready;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [BEW-1:0] wr_be  = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en   = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  ram_sync_dp_be #(
    .AWIDTH (AW),
    .DWIDTH (DW),
    .OUT_REG(OUT_REG)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .ready   (ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: plain word array, remaining sweep cycles, queue of due reads.
  logic [DW-1:0] mmem [DEPTH];
  int            sweep_left = DEPTH;
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_t;
  rd_t           rq[$];
  logic          e_valid = 1'b0;
  logic          e_ready = 1'b0;
  logic [DW-1:0] e_rdata = '0;

  function automatic logic [DW-1:0] byte_mask(input logic [BEW-1:0] be);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < BEW; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic model_reset();
    sweep_left = DEPTH;
    rq.delete();
    e_valid = 1'b0;
    e_ready = 1'b0;
    e_rdata = '0;
  endtask

  // Drive one clock cycle of inputs, advance the model, and land on the next negedge.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [BEW-1:0] be,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic clr);
    logic [DW-1:0] m;
    logic [DW-1:0] rdv;
    logic          rdy;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra; clear = clr;
    rdy = (sweep_left == 0);
    m   = byte_mask(be);
    if (rdy && re) begin
      rdv = mmem[ra];
`ifdef RAM_RDW_BYPASS_EN
      if (we && !clr && wa == ra) rdv = (rdv & ~m) | (wd & m);
`endif
      rq.push_back('{cyc + 1 + LAT, rdv});
    end
    if (rdy) begin
      if (we && !clr) mmem[wa] = (mmem[wa] & ~m) | (wd & m);
      if (clr) sweep_left = DEPTH;
    end else begin
      mmem[DEPTH - sweep_left] = '0;
      sweep_left = clr ? DEPTH : sweep_left - 1;
    end
    @(negedge clock);
    cyc++;
    e_ready = (sweep_left == 0);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_valid = 1'b1;
      e_rdata = rq[0].d;
      void'(rq.pop_front());
    end else begin
      e_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({ready, rd_valid, rd_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready/valid/data=%b/%b/%h, expected 0/0/00000000", ready, rd_valid, rd_data);
    end
    reset_n = 1'b1;
    model_reset();
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_ready: ready=%b, expected 0", ready);
    end
    for (int i = 0; i < DEPTH + DEPTH + LAT; i++) begin
      if (i < DEPTH) step(0, '0, '0, '0, 0, '0, 0);
      else if (i < 2 * DEPTH) step(0, '0, '0, '0, 1, AW'(i - DEPTH), 0);
      else step(0, '0, '0, '0, 0, '0, 0);
      n_checks++;
      if ({ready, rd_valid, rd_data} !== {e_ready, e_valid, e_rdata}) begin
        n_fail++;
        $display("FAIL sweep_and_zero cyc=%0d: ready/valid/data=%b/%b/%h, expected %b/%b/%h",
                 cyc, ready, rd_valid, rd_data, e_ready, e_valid, e_rdata);
      end
    end
  endtask

  task automatic test_byte_enable();
    for (int i = 0; i < 3 + LAT; i++) begin
      if (i == 0) step(1, 3'd3, 4'hF, 32'hDEADBEEF, 0, '0, 0);
      else if (i == 1) step(1, 3'd3, 4'b0101, 32'h11223344, 0, '0, 0);
      else if (i == 2) step(0, '0, '0, '0, 1, 3'd3, 0);
      else step(0, '0, '0, '0, 0, '0, 0);
      n_checks++;
      if ({ready, rd_valid, rd_data} !== {e_ready, e_valid, e_rdata}) begin
        n_fail++;
        $display("FAIL byte_enable cyc=%0d: ready/valid/data=%b/%b/%h, expected %b/%b/%h",
                 cyc, ready, rd_valid, rd_data, e_ready, e_valid, e_rdata);
      end
    end
    n_checks++;
    if (rd_data !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL byte_merge_value: rd_data=%h, expected de22be44", rd_data);
    end
  endtask

  task automatic test_rdw_same_addr();
    logic [DW-1:0] exp_first;
`ifdef RAM_RDW_BYPASS_EN
    exp_first = 32'hAAAA5555;
`else
    exp_first = 32'h00000000;
`endif
    for (int i = 0; i < 1 + LAT; i++) begin
      if (i == 0) step(1, 3'd5, 4'hF, 32'hAAAA5555, 1, 3'd5, 0);
      else step(0, '0, '0, '0, 0, '0, 0);
      n_checks++;
      if ({ready, rd_valid, rd_data} !== {e_ready, e_valid, e_rdata}) begin
        n_fail++;
        $display("FAIL rdw_same_addr cyc=%0d: ready/valid/data=%b/%b/%h, expected %b/%b/%h",
                 cyc, ready, rd_valid, rd_data, e_ready, e_valid, e_rdata);
      end
    end
    n_checks++;
    if (rd_data !== exp_first) begin
      n_fail++;
      $display("FAIL rdw_first_read: rd_data=%h, expected %h", rd_data, exp_first);
    end
    for (int i = 0; i < 1 + LAT; i++) begin
      if (i == 0) step(0, '0, '0, '0, 1, 3'd5, 0);
      else step(0, '0, '0, '0, 0, '0, 0);
    end
    n_checks++;
    if (rd_data !== 32'hAAAA5555 || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rdw_second_read: valid=%b data=%h, expected 1 aaaa5555", rd_valid, rd_data);
    end
  endtask

  task automatic test_clear_drops_write();
    // Clear, a write to addr 2 and a read of addr 3 share one cycle; the read still completes.
    for (int i = 0; i < 1 + DEPTH + 1 + LAT; i++) begin
      if (i == 0) step(1, 3'd2, 4'hF, 32'h12345678, 1, 3'd3, 1);
      else if (i == DEPTH + 1) step(0, '0, '0, '0, 1, 3'd2, 0);
      else step(0, '0, '0, '0, 0, '0, 0);
      n_checks++;
      if ({ready, rd_valid, rd_data} !== {e_ready, e_valid, e_rdata}) begin
        n_fail++;
        $display("FAIL clear_drops_write cyc=%0d: ready/valid/data=%b/%b/%h, expected %b/%b/%h",
                 cyc, ready, rd_valid, rd_data, e_ready, e_valid, e_rdata);
      end
    end
    n_checks++;
    if (rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL clear_addr2_zero: rd_data=%h, expected 00000000", rd_data);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [DW-1:0] v;
    v = $urandom() | 32'h1;
    step(1, 3'd1, 4'hF, v, 0, '0, 0);
    step(0, '0, '0, '0, 1, 3'd1, 0);
    repeat (LAT) step(0, '0, '0, '0, 0, '0, 0);
    n_checks++;
    if (rd_data !== v) begin
      n_fail++;
      $display("FAIL pre_reset_read: rd_data=%h, expected %h", rd_data, v);
    end
    step(0, '0, '0, '0, 0, '0, 1);
    repeat (4) step(0, '0, '0, '0, 0, '0, 0);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({ready, rd_valid, rd_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_sweep: ready/valid/data=%b/%b/%h, expected 0/0/00000000", ready, rd_valid, rd_data);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(0, '0, '0, '0, 1, 3'd1, 0);
      n_checks++;
      if ({ready, rd_valid, rd_data} !== {e_ready, e_valid, e_rdata}) begin
        n_fail++;
        $display("FAIL resweep cyc=%0d: ready/valid/data=%b/%b/%h, expected %b/%b/%h",
                 cyc, ready, rd_valid, rd_data, e_ready, e_valid, e_rdata);
      end
    end
    repeat (LAT) step(0, '0, '0, '0, 0, '0, 0);
  endtask

  task automatic test_reset_drops_read();
    step(1, 3'd6, 4'hF, 32'hCAFEF00D, 0, '0, 0);
    step(0, '0, '0, '0, 1, 3'd6, 0);
    #1 reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clock);
      n_checks++;
      if ({ready, rd_valid, rd_data} !== '0) begin
        n_fail++;
        $display("FAIL reset_drops_read %0d: ready/valid/data=%b/%b/%h, expected 0/0/00000000",
                 i, ready, rd_valid, rd_data);
      end
    end
    reset_n = 1'b1;
    repeat (DEPTH) step(0, '0, '0, '0, 0, '0, 0);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_resweep: ready=%b, expected 1", ready);
    end
  endtask

  task automatic test_back_to_back();
    int n_valid;
    n_valid = 0;
    for (int a = 0; a < DEPTH; a++) step(1, AW'(a), 4'hF, DW'(a), 0, '0, 0);
    for (int i = 0; i < DEPTH + LAT; i++) begin
      if (i < DEPTH) step(0, '0, '0, '0, 1, AW'(i), 0);
      else step(0, '0, '0, '0, 0, '0, 0);
      if (rd_valid === 1'b1) n_valid++;
      n_checks++;
      if ({ready, rd_valid, rd_data} !== {e_ready, e_valid, e_rdata}) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d: ready/valid/data=%b/%b/%h, expected %b/%b/%h",
                 cyc, ready, rd_valid, rd_data, e_ready, e_valid, e_rdata);
      end
    end
    n_checks++;
    if (n_valid != DEPTH) begin
      n_fail++;
      $display("FAIL back_to_back_count: valid pulses=%0d, expected %0d", n_valid, DEPTH);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom()), BEW'($urandom()), $urandom(),
           1'($urandom_range(0, 1)), AW'($urandom()), ($urandom_range(0, 39) == 0));
      n_checks++;
      if ({ready, rd_valid, rd_data} !== {e_ready, e_valid, e_rdata}) begin
        n_fail++;
        $display("FAIL random cyc=%0d: ready/valid/data=%b/%b/%h, expected %b/%b/%h",
                 cyc, ready, rd_valid, rd_data, e_ready, e_valid, e_rdata);
      end
    end
    repeat (LAT + DEPTH) step(0, '0, '0, '0, 0, '0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    test_reset();
    test_byte_enable();
    test_rdw_same_addr();
    test_clear_drops_write();
    test_reset_mid_sweep();
    test_reset_drops_read();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
